stopwatch_input_conditioner: RTL

//  Front end for the stopwatch display/counter stage. Conditions the raw start/stop and clear push-buttons:
//  2-FF synchronisation, debounce, press-edge detection. Holds the run/stop state and generates the
//  10 ms count-enable tick. Outputs drive the downstream digit counter directly: run, tick, clr.

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/button_debounce.sv | 65 ++++++
 rtl/stopwatch_input_conditioner.sv | 94 +++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch input front end.
package stopwatch_pkg;

   // Board clock and the real-time defaults derived from it.
   localparam int unsigned CLK_FREQ_HZ      = 100_000_000;
   localparam int unsigned DB_CNT_DEFAULT   = CLK_FREQ_HZ / 100;  // 10 ms stable time
   localparam int unsigned TICK_DIV_DEFAULT = CLK_FREQ_HZ / 100;  // 100 Hz count tick

   // Short values so simulation reaches every corner in a few hundred cycles.
   localparam int unsigned DB_CNT_SIM   = 4;
   localparam int unsigned TICK_DIV_SIM = 5;

   // Run/stop state of the stopwatch.
   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } run_state_e;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button: 2-FF synchroniser, stability-count debounce and
// registered rising-edge (press) detect.
module button_debounce
   import stopwatch_pkg::*;
#(
   parameter int unsigned DB_CNT = DB_CNT_DEFAULT
) (
   input  logic clk,
   input  logic r_n,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int unsigned     CW       = cnt_w(DB_CNT);
   // A change is accepted on the DB_CNT-th consecutive differing cycle,
   // so the counter never needs to hold more than DB_CNT-1.
   localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CNT - 1);

   logic          sync_q1;
   logic          sync;
   logic [CW-1:0] cnt;
   logic          level_d;

   // Bring the asynchronous pin into the clk domain; nothing else reads btn_raw.
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         sync_q1 <= 1'b0;
         sync    <= 1'b0;
      end else begin
         sync_q1 <= btn_raw;
         sync    <= sync_q1;
      end
   end

   // Accept a new level only after it has differed for DB_CNT straight cycles;
   // any agreement in between restarts the count, so short glitches vanish.
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync != level) begin
         if (cnt == CNT_LAST) begin
            level <= sync;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         cnt <= '0;
      end
   end

   // One-cycle press pulse in the cycle after the debounced level rises.
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         level_d <= 1'b0;
         press   <= 1'b0;
      end else begin
         level_d <= level;
         press   <= level & ~level_d;
      end
   end

endmodule

// File: rtl/stopwatch_input_conditioner.sv
// Stopwatch front end: debounces start/stop and clear buttons, holds the
// run state and produces the count-enable tick for the digit counter.
module stopwatch_input_conditioner
   import stopwatch_pkg::*;
#(
   parameter int unsigned DB_CNT   = DB_CNT_DEFAULT,
   parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
   input  logic clk,
   input  logic r_n,
   input  logic s_btn,
   input  logic r_btn,
   output logic run,
   output logic tick,
   output logic clr,
   output logic s_level,
   output logic r_level
);

   localparam int unsigned   DW       = cnt_w(TICK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

   logic          s_press;
   logic          r_press;
   run_state_e    state;
   run_state_e    state_nxt;
   logic          clr_nxt;
   logic [DW-1:0] div;

   button_debounce #(.DB_CNT(DB_CNT)) u_s_db (
      .clk     (clk),
      .r_n     (r_n),
      .btn_raw (s_btn),
      .level   (s_level),
      .press   (s_press)
   );

   button_debounce #(.DB_CNT(DB_CNT)) u_r_db (
      .clk     (clk),
      .r_n     (r_n),
      .btn_raw (r_btn),
      .level   (r_level),
      .press   (r_press)
   );

   // Run state register and the registered clear pulse.
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         state <= ST_STOP;
         clr   <= 1'b0;
      end else begin
         state <= state_nxt;
         clr   <= clr_nxt;
      end
   end

   // Clear stops the watch and wins over a start/stop press in the same cycle.
   always_comb begin
      state_nxt = state;
      clr_nxt   = 1'b0;
      if (r_press) begin
         state_nxt = ST_STOP;
         clr_nxt   = 1'b1;
      end else if (s_press) begin
         state_nxt = (state == ST_RUN) ? ST_STOP : ST_RUN;
      end
   end

   assign run = (state == ST_RUN);

   // Tick divider: advances only while running so a pause keeps the phase;
   // the clear pulse restarts it so a fresh start gets a full first period.
   // run is the registered value, so a stop landing on the wrap edge still
   // issues that wrap's tick.
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         div  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (clr) begin
            div <= '0;
         end else if (run) begin
            if (div == DIV_LAST) begin
               div  <= '0;
               tick <= 1'b1;
            end else begin
               div <= div + 1'b1;
            end
         end
      end
   end

endmodule
